// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    typedef logic [AW-1:0] rf_addr_t;
    typedef logic [DW-1:0] rf_data_t;

    typedef struct packed {
        logic     valid;
        rf_addr_t wa;
        rf_data_t wd;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner and grants
// the first active request. The pointer moves only when the grant is used.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_adv,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx
);

    logic [IW-1:0] r_ptr;
    int            w_cand;
    logic          w_hit;
    logic          w_found;

    // Priority search beginning at (ptr+1) mod NREQ, wrapping once around.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        w_hit   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand  = (int'(r_ptr) + k) % NREQ;
            w_hit   = ~w_found & i_req[w_cand];
            o_grant = o_grant | ({{(NREQ-1){1'b0}}, w_hit} << w_cand);
            o_idx   = w_hit ? IW'(w_cand) : o_idx;
            w_found = w_found | w_hit;
        end
    end

    // Pointer remembers the last winner; reset value makes requester 0 first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IW'(NREQ - 1);
        end else if (i_adv) begin
            r_ptr <= o_idx;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port among NREQ writeback requesters and
// tracks registers with outstanding writes in a busy scoreboard.
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = rf_pkg::AW,
    parameter int DW   = rf_pkg::DW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*AW-1:0]  req_wa,
    input  logic [NREQ*DW-1:0]  req_wd,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ready,
    output logic [2**AW-1:0]    busy,
    output logic                we3,
    output logic [AW-1:0]       wa3,
    output logic [DW-1:0]       wd3
);
    import rf_pkg::*;

    localparam int NRF = 2 ** AW;
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_idx;
    logic            w_xfer;
    logic [AW-1:0]   w_wa;
    logic [DW-1:0]   w_wd;
    logic            w_rsv_ready;
    logic [NRF-1:0]  w_set;
    logic [NRF-1:0]  w_clr;
    logic [NRF-1:0]  w_busy_nxt;

    logic            r_we;
    logic [AW-1:0]   r_wa;
    logic [DW-1:0]   r_wd;
    logic [NRF-1:0]  r_busy;

    // One-hot decode of a register address.
    function automatic logic [NRF-1:0] addr_dec(input logic [AW-1:0] a);
        logic [NRF-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (req_valid),
        .i_adv   (w_xfer),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Grant is suppressed during reset; select the winning slice.
    always_comb begin
        req_ready = w_grant & {NREQ{rst_n}};
        w_xfer    = |(req_valid & req_ready);
        w_wa      = req_wa[int'(w_idx)*AW +: AW];
        w_wd      = req_wd[int'(w_idx)*DW +: DW];
    end

    // Output stage: a transfer becomes a regfile write one cycle later; writes
    // to register 0 are dropped and the data registers keep their old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we <= 1'b0;
            r_wa <= '0;
            r_wd <= '0;
        end else if (w_xfer && (w_wa != '0)) begin
            r_we <= 1'b1;
            r_wa <= w_wa;
            r_wd <= w_wd;
        end else begin
            r_we <= 1'b0;
        end
    end

    // Scoreboard next state: clear on committing write, set on accepted
    // reservation; set is applied last so it wins on a same-address collision.
    always_comb begin
        w_rsv_ready   = ~r_busy[rsv_addr];
        w_clr         = r_we ? addr_dec(r_wa) : '0;
        w_set         = (rsv_valid && w_rsv_ready && (rsv_addr != '0)) ? addr_dec(rsv_addr) : '0;
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign rsv_ready = w_rsv_ready;
    assign busy      = r_busy;
    assign we3       = r_we;
    assign wa3       = r_wa;
    assign wd3       = r_wd;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NRF  = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*AW-1:0]  req_wa;
    logic [NREQ*DW-1:0]  req_wd;
    logic                rsv_valid;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ready;
    logic [NRF-1:0]      busy;
    logic                we3;
    logic [AW-1:0]       wa3;
    logic [DW-1:0]       wd3;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    int              m_ptr;
    logic            m_we;
    logic [AW-1:0]   m_wa;
    logic [DW-1:0]   m_wd;
    logic [NRF-1:0]  m_busy;
    logic [NREQ-1:0] exp_ready;
    logic            exp_rsv_ready;
    int              last_g;

    logic [AW-1:0] rr_seq [4] = '{5'd1, 5'd2, 5'd3, 5'd1};

    rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wa    (req_wa),
        .req_wd    (req_wd),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .busy      (busy),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = NREQ - 1;
        m_we   = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
        m_busy = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]       = v;
        req_wa[i*AW +: AW] = a;
        req_wd[i*DW +: DW] = d;
    endtask

    // One clock cycle: predict combinational outputs, then advance the model.
    task automatic step();
        int            g;
        logic [AW-1:0] a;
        logic [NREQ-1:0] one;
        one = 1;
        if (!rst_n) model_reset();
        g             = rst_n ? model_pick(req_valid, m_ptr) : -1;
        exp_ready     = (g >= 0) ? (one << g) : '0;
        exp_rsv_ready = ~m_busy[rsv_addr];
        last_g        = g;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_we) m_busy[m_wa] = 1'b0;
            if (rsv_valid && exp_rsv_ready && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
            if (g >= 0) begin
                a     = req_wa[g*AW +: AW];
                m_ptr = g;
                m_we  = (a != 0);
                if (a != 0) begin
                    m_wa = a;
                    m_wd = req_wd[g*DW +: DW];
                end
            end else begin
                m_we = 1'b0;
            end
        end
        #1;
    endtask

    task automatic hard_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsv_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("rsv_ready", 64'(rsv_ready), 64'(exp_rsv_ready));
            chk("we3", 64'(we3), 64'(m_we));
            if (m_we || !rst_n) begin
                chk("wa3", 64'(wa3), 64'(m_wa));
                chk("wd3", 64'(wd3), 64'(m_wd));
            end
            chk("busy", 64'(busy), 64'(m_busy));
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_wa    = '0;
        req_wd    = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        last_g    = -1;
        model_reset();
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset held with toggling inputs
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom());
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = AW'($urandom_range(0, 31));
            step();
            chk("rst_we3", 64'(we3), 64'(1'b0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_ready", 64'(req_ready), 64'(0));
            chk("rst_wa3", 64'(wa3), 64'(0));
        end

        // Reset release: requester 2 alone is granted immediately
        req_valid = '0;
        rsv_valid = 1'b0;
        set_req(2, 1'b1, 5'd4, 32'h0000_1234);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 64'(req_ready), 64'(3'b100));
        step();
        req_valid = '0;

        // Single requester, one-cycle latency
        set_req(1, 1'b1, 5'd7, 32'hDEAD_BEEF);
        #1;
        chk("single_ready", 64'(req_ready), 64'(3'b010));
        step();
        req_valid = '0;
        chk("single_we3", 64'(we3), 64'(1'b1));
        chk("single_wa3", 64'(wa3), 64'(5'd7));
        chk("single_wd3", 64'(wd3), 64'(32'hDEAD_BEEF));
        step();
        chk("single_we3_off", 64'(we3), 64'(1'b0));

        // Round robin with all requesters held from reset
        hard_reset();
        set_req(0, 1'b1, 5'd1, $urandom());
        set_req(1, 1'b1, 5'd2, $urandom());
        set_req(2, 1'b1, 5'd3, $urandom());
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_we3", 64'(we3), 64'(1'b1));
            chk("rr_wa3", 64'(wa3), 64'(rr_seq[k]));
        end
        req_valid = '0;

        // Address 0 consumes the grant but never writes
        hard_reset();
        set_req(0, 1'b1, 5'd0, 32'h1111_1111);
        set_req(1, 1'b1, 5'd6, 32'h6666_6666);
        #1;
        chk("a0_ready", 64'(req_ready), 64'(3'b001));
        step();
        req_valid[0] = 1'b0;
        chk("a0_we3", 64'(we3), 64'(1'b0));
        #1;
        chk("a0_next_ready", 64'(req_ready), 64'(3'b010));
        step();
        req_valid = '0;
        chk("a0_next_we3", 64'(we3), 64'(1'b1));
        chk("a0_next_wa3", 64'(wa3), 64'(5'd6));

        // Scoreboard set / refuse / clear / re-reserve
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        #1;
        chk("sb_rsv_t", 64'(rsv_ready), 64'(1'b1));
        step();
        chk("sb_busy9_set", 64'(busy[9]), 64'(1'b1));
        chk("sb_rsv_again", 64'(rsv_ready), 64'(1'b0));
        step();
        rsv_valid = 1'b0;
        step();
        set_req(2, 1'b1, 5'd9, 32'h9999_0009);
        step();
        req_valid = '0;
        chk("sb_we3", 64'(we3), 64'(1'b1));
        chk("sb_wa3", 64'(wa3), 64'(5'd9));
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        #1;
        chk("sb_rsv_t4", 64'(rsv_ready), 64'(1'b0));
        step();
        chk("sb_busy9_clr", 64'(busy[9]), 64'(1'b0));
        chk("sb_rsv_t5", 64'(rsv_ready), 64'(1'b1));
        step();
        rsv_valid = 1'b0;
        chk("sb_busy9_reset", 64'(busy[9]), 64'(1'b1));

        // Mid-operation reset pulse right after a transfer
        set_req(1, 1'b1, 5'd12, 32'hCAFE_0012);
        step();
        req_valid = '0;
        chk_en    = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        chk("mid_we3", 64'(we3), 64'(1'b0));
        chk("mid_busy", 64'(busy), 64'(0));
        #4;
        rst_n = 1'b1;
        set_req(0, 1'b1, 5'd1, $urandom());
        set_req(1, 1'b1, 5'd2, $urandom());
        set_req(2, 1'b1, 5'd3, $urandom());
        #1;
        chk("mid_we3_after", 64'(we3), 64'(1'b0));
        chk("mid_ready", 64'(req_ready), 64'(3'b001));
        chk_en = 1'b1;
        step();
        req_valid = '0;
        step();

        // Randomized traffic against the model
        last_g = -1;
        for (int c = 0; c < 3000; c++) begin
            if (last_g >= 0) req_valid[last_g] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 60)
                    set_req(i, 1'b1, AW'($urandom_range(0, 7)), $urandom());
            end
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = AW'($urandom_range(0, 7));
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
